task_6_input: RTL and testbench

//  Receive side of the task-6 byte-stream interface: accepts one packet from the task manager
//  (valid/ready/last), checks its length against the task-6 packet size, buffers it, then

---
 rtl/task_pkg.sv | 20 ++
 rtl/task_6_input_fifo.sv | 85 ++++++++
 rtl/task_6_input.sv | 178 +++++++++++++++++
 tb/tb_task_6_input.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_pkg.sv
// Shared definitions for the task-6 byte-stream blocks.
// Holds the task-6 packet size, the input buffer depth and the
// state type used by the receive-side controller.
package task_pkg;

  // Required length of a task-6 input packet, in bytes (1..4095).
  localparam int TASK_6_PKT_SIZE_IN_BYTES = 8;

  // Input buffer entries; a power of two no smaller than the packet size.
  localparam int TASK_6_IN_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RECEIVE = 3'd1,
    S_DISCARD = 3'd2,
    S_FLUSH   = 3'd3,
    S_DRAIN   = 3'd4
  } task_input_enum;

endpackage

// File: rtl/task_6_input_fifo.sv
// Show-ahead synchronous FIFO for the task-6 input path.
// q always presents the head entry; rdreq pops it.
// Ports:
//   clock         clock
//   aclr          asynchronous clear, active-high
//   sclr          synchronous clear
//   data, wrreq   write port (ignored when full)
//   rdreq         pop the head (ignored when empty)
//   q             head entry
//   empty, full   status flags
//   usedw         number of stored entries
module task_6_input_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              sclr,
  input  logic [DATA_W-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       usedw
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       cnt_r;
  logic              do_wr_s;
  logic              do_rd_s;

  // Pointer advance with explicit wrap so non-power-of-two depths also work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + AW'(1);
    end
  endfunction

  assign do_wr_s = wrreq & ~full;
  assign do_rd_s = rdreq & ~empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else if (sclr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_rd_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  assign q     = mem_r[rd_ptr_r];
  assign empty = (cnt_r == (AW+1)'(0));
  assign full  = (cnt_r == (AW+1)'(DEPTH));
  assign usedw = cnt_r;

endmodule

// File: rtl/task_6_input.sv
// Receive side of the task-6 byte-stream interface.
// Accepts one packet from the task manager, checks its length against
// PKT_SIZE, buffers it and streams good packets to the task-6 core.
// Short and long packets are dropped and flagged with o_pkt_err.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_tmanager_data/valid/last    byte stream from the manager
//   o_tinput_ready                manager byte accepted this cycle when valid
//   o_data/o_data_valid/o_data_last  byte stream to the core (FIFO head)
//   i_task_ready                  core consumes o_data when valid
//   o_busy                        packet in progress
//   o_pkt_err                     one-cycle length-error pulse
//   o_byte_cnt                    bytes accepted in the current packet
module task_6_input
  import task_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PKT_SIZE   = TASK_6_PKT_SIZE_IN_BYTES,
  parameter int FIFO_DEPTH = TASK_6_IN_FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_tmanager_data,
  input  logic              i_tmanager_valid,
  input  logic              i_tmanager_last,
  output logic              o_tinput_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_data_last,
  input  logic              i_task_ready,
  output logic              o_busy,
  output logic              o_pkt_err,
  output logic [11:0]       o_byte_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [12:0] PKT_LEN = 13'(PKT_SIZE);

  task_input_enum    state_r;
  task_input_enum    state_next_s;
  logic [11:0]       cnt_r;
  logic              err_r;
  logic              err_next_s;
  logic [12:0]       cnt_inc_s;
  logic              at_size_s;
  logic              under_size_s;
  logic              ready_s;
  logic              accept_s;
  logic              data_valid_s;
  logic              pop_s;
  logic [DATA_W-1:0] fifo_q_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [AW:0]       fifo_usedw_s;

  // One bit wider so the compare against PKT_SIZE cannot wrap.
  assign cnt_inc_s    = {1'b0, cnt_r} + 13'd1;
  assign at_size_s    = (cnt_inc_s == PKT_LEN);
  assign under_size_s = (cnt_inc_s <  PKT_LEN);

  assign accept_s     = i_tmanager_valid & ready_s;
  assign data_valid_s = (state_r == S_DRAIN) & ~fifo_empty_s;
  assign pop_s        = data_valid_s & i_task_ready;

  // Manager-side ready: buffering in S_RECEIVE, swallowing bytes in S_DISCARD.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      S_RECEIVE: ready_s = ~fifo_full_s;
      S_DISCARD: ready_s = 1'b1;
      default:   ready_s = 1'b0;
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        state_next_s = S_RECEIVE;
      end
      S_RECEIVE: begin
        if (accept_s) begin
          if (i_tmanager_last) begin
            state_next_s = at_size_s ? S_DRAIN : S_FLUSH;
          end else if (at_size_s) begin
            state_next_s = S_DISCARD;
          end else begin
            state_next_s = S_RECEIVE;
          end
        end else begin
          state_next_s = S_RECEIVE;
        end
      end
      S_DISCARD: begin
        if (accept_s && i_tmanager_last) begin
          state_next_s = S_FLUSH;
        end else begin
          state_next_s = S_DISCARD;
        end
      end
      S_FLUSH: begin
        state_next_s = S_IDLE;
      end
      S_DRAIN: begin
        // Leave on the final pop so the inter-packet gap is a single S_IDLE cycle.
        if (fifo_empty_s || (pop_s && (fifo_usedw_s == (AW+1)'(1)))) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DRAIN;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Length error: short packet ends early, or the size-th byte is not the last.
  always_comb begin
    err_next_s = 1'b0;
    if ((state_r == S_RECEIVE) && accept_s) begin
      err_next_s = i_tmanager_last ? under_size_s : at_size_s;
    end else begin
      err_next_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Byte counter and error pulse; the counter freezes at PKT_SIZE in S_DISCARD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= 12'd0;
      err_r <= 1'b0;
    end else begin
      err_r <= err_next_s;
      if (state_next_s == S_IDLE) begin
        cnt_r <= 12'd0;
      end else if ((state_r == S_RECEIVE) && accept_s) begin
        cnt_r <= cnt_inc_s[11:0];
      end
    end
  end

  task_6_input_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock (i_clk),
    .aclr  (i_rst),
    .sclr  (state_r == S_FLUSH),
    .data  (i_tmanager_data),
    .wrreq ((state_r == S_RECEIVE) & accept_s),
    .rdreq (pop_s),
    .q     (fifo_q_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .usedw (fifo_usedw_s)
  );

  // o_data is forced to zero when not valid so the whole output set is 0 in reset.
  assign o_tinput_ready = ready_s;
  assign o_data         = data_valid_s ? fifo_q_s : {DATA_W{1'b0}};
  assign o_data_valid   = data_valid_s;
  assign o_data_last    = data_valid_s & (fifo_usedw_s == (AW+1)'(1));
  assign o_busy         = (state_r != S_IDLE);
  assign o_pkt_err      = err_r;
  assign o_byte_cnt     = cnt_r;

endmodule

// File: tb/tb_task_6_input.sv
// Scoreboard bench for task_6_input: packets are issued by a driver that
// pushes the expected core-side bytes into a queue, and a monitor pops and
// compares whenever the core consumes a byte.
module tb_task_6_input;
  import task_pkg::*;

  localparam int PKT = TASK_6_PKT_SIZE_IN_BYTES;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_tmanager_data = 8'h00;
  logic        i_tmanager_valid = 1'b0;
  logic        i_tmanager_last = 1'b0;
  logic        o_tinput_ready;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        o_data_last;
  logic        i_task_ready = 1'b1;
  logic        o_busy;
  logic        o_pkt_err;
  logic [11:0] o_byte_cnt;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops = 0;
  int   rdy_mode = 0;

  task_6_input dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_tmanager_data  (i_tmanager_data),
    .i_tmanager_valid (i_tmanager_valid),
    .i_tmanager_last  (i_tmanager_last),
    .o_tinput_ready   (o_tinput_ready),
    .o_data           (o_data),
    .o_data_valid     (o_data_valid),
    .o_data_last      (o_data_last),
    .i_task_ready     (i_task_ready),
    .o_busy           (o_busy),
    .o_pkt_err        (o_pkt_err),
    .o_byte_cnt       (o_byte_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endfunction

  // Core-side ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0: i_task_ready = 1'b1;
        1: begin
          i_task_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: i_task_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor: compares consumed bytes against the scoreboard and checks stall/err rules.
  initial begin
    logic       stall;
    logic [7:0] held;
    logic       perr;
    exp_t       e;
    stall = 1'b0;
    perr  = 1'b0;
    held  = 8'h00;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        stall = 1'b0;
        perr  = 1'b0;
      end else begin
        if (o_data_valid) check("ready_low_in_drain", o_tinput_ready, 0);
        if (!o_data_valid) check("last_without_valid", o_data_last, 0);
        if (stall) begin
          check("valid_held", o_data_valid, 1);
          check("data_held", o_data, held);
        end
        if (o_data_valid && i_task_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", o_data_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("data", o_data, e.d);
            check("last", o_data_last, e.l);
          end
          pops++;
        end
        if (perr) check("err_width", o_pkt_err, 0);
        stall = o_data_valid & ~i_task_ready;
        held  = o_data;
        perr  = o_pkt_err;
      end
    end
  end

  // Drive one packet. gap_mode: 0 continuous, 1 every other cycle, 2 random.
  task automatic send(input int len, input bit with_last, input int gap_mode,
                      input logic [7:0] base, input bit rand_data);
    logic [7:0] pkt[$];
    int   acc;
    int   cyc;
    bit   err_due;
    bit   last_k;
    exp_t e;
    for (int k = 0; k < len; k++) begin
      pkt.push_back(rand_data ? 8'($urandom) : base + 8'(k));
    end
    // Only an exactly sized, properly terminated packet reaches the core.
    if (with_last && len == PKT) begin
      for (int k = 0; k < len; k++) begin
        e.d = pkt[k];
        e.l = (k == len - 1);
        exp_q.push_back(e);
      end
    end
    acc = 0;
    cyc = 0;
    err_due = 1'b0;
    while (acc < len && cyc < 400) begin
      @(posedge i_clk);
      #1;
      case (gap_mode)
        0:       i_tmanager_valid = 1'b1;
        1:       i_tmanager_valid = (cyc % 2 == 0);
        default: i_tmanager_valid = ($urandom_range(0, 3) != 0);
      endcase
      last_k = with_last && (acc == len - 1);
      i_tmanager_data = pkt[acc];
      i_tmanager_last = last_k;
      @(negedge i_clk);
      cyc++;
      check("pkt_err", o_pkt_err, err_due);
      err_due = 1'b0;
      if (o_tinput_ready) check("byte_cnt", o_byte_cnt, (acc < PKT) ? acc : PKT);
      if (i_tmanager_valid && o_tinput_ready) begin
        acc++;
        err_due = (acc == PKT && !last_k) || (last_k && acc < PKT);
      end
    end
    if (acc < len) check("send_timeout", acc, len);
    @(posedge i_clk);
    #1;
    i_tmanager_valid = 1'b0;
    i_tmanager_last  = 1'b0;
    @(negedge i_clk);
    check("pkt_err", o_pkt_err, err_due);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_flags"}, {o_tinput_ready, o_data_valid, o_data_last, o_busy, o_pkt_err}, 0);
    check({name, "_data"}, o_data, 0);
    check({name, "_cnt"}, o_byte_cnt, 0);
  endtask

  task automatic reset_pulse(input string name);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check_all_zero(name);
    exp_q.delete();
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    int len;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Good packet, core always ready; busy drops in the cycle after the last pop.
    send(8, 1'b1, 0, 8'h10, 1'b0);
    wait_drain();
    @(negedge i_clk);
    check("busy_after_drain", o_busy, 0);

    // Short packet: error pulse, flushed, back in S_IDLE two cycles after the last accept.
    send(5, 1'b1, 0, 8'h20, 1'b0);
    @(negedge i_clk);
    check("short_idle_busy", o_busy, 0);
    check("short_no_valid", o_data_valid, 0);

    // Long packet followed by a good one.
    send(11, 1'b1, 0, 8'h40, 1'b0);
    send(8, 1'b1, 0, 8'hA0, 1'b0);
    wait_drain();

    // Core backpressure 1,0,0 pattern.
    rdy_mode = 1;
    send(8, 1'b1, 0, 8'h00, 1'b1);
    wait_drain();
    rdy_mode = 0;

    // Manager valid every other cycle.
    send(8, 1'b1, 1, 8'h30, 1'b0);
    wait_drain();

    // Reset after 4 bytes of a packet, then a clean packet.
    send(4, 1'b0, 0, 8'h50, 1'b0);
    reset_pulse("rst_mid_receive");
    send(8, 1'b1, 0, 8'h58, 1'b0);
    wait_drain();

    // Reset after 3 pops of a drain, then a clean packet.
    base = pops;
    send(8, 1'b1, 0, 8'h60, 1'b0);
    n = 0;
    while ((pops - base) < 3 && n < 100) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("pops_before_reset", pops - base, 3);
    reset_pulse("rst_mid_drain");
    send(8, 1'b1, 0, 8'h70, 1'b0);
    wait_drain();

    // Randomized mix of good, short and long packets with random gaps and stalls.
    rdy_mode = 2;
    for (int p = 0; p < 25; p++) begin
      len = ($urandom_range(0, 1) == 1) ? PKT : int'($urandom_range(1, 12));
      send(len, 1'b1, 2, 8'h00, 1'b1);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(negedge i_clk);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
